sobel_edge3x3: RTL and testbench

Pipelined 3x3 Sobel gradient stage that consumes the three-tap pixel windows produced by three stacked window shift registers (top, middle and bottom image rows). On every load strobe it computes Gx, Gy and the L1 magnitude, then thresholds the magnitude into an edge flag for the feature-detection front end of the SLAM pipeline. It also tracks pixel position so that outputs whose window lies across a line or frame border are suppressed.

---
 rtl/sobel_edge3x3_pkg.sv | 31 +++
 rtl/sobel_edge3x3_win_pos_cnt.sv | 64 ++++++
 rtl/sobel_edge3x3.sv | 100 ++++++++++
 tb/tb_sobel_edge3x3.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_edge3x3_pkg.sv
// Shared widths, default geometry and small arithmetic helpers for the Sobel stage.
package sobel_edge3x3_pkg;

  localparam int unsigned DefImgW   = 640;
  localparam int unsigned DefImgH   = 480;
  localparam int unsigned DefWinLag = 5;
  localparam int unsigned DefThresh = 100;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned GRAD_W = 11;
  localparam int unsigned MAG_W  = 11;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic        [SUM_W-1:0]  sum_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic        [MAG_W-1:0]  mag_t;

  // 1-2-1 weighted sum of three taps; max 1020 fits in SUM_W.
  function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
    return sum_t'(a) + sum_t'({b, 1'b0}) + sum_t'(c);
  endfunction

  // |pos - neg| via a signed gradient; the magnitude always fits back in SUM_W.
  function automatic sum_t abs_grad(input sum_t pos, input sum_t neg);
    grad_t g;
    g = $signed({1'b0, pos}) - $signed({1'b0, neg});
    return g[GRAD_W-1] ? sum_t'(-g) : sum_t'(g);
  endfunction

endpackage

// File: rtl/sobel_edge3x3_win_pos_cnt.sv
// Pixel position tracking: col/row counters, sof resync, window qualification, frame_done.
module win_pos_cnt
  import sobel_edge3x3_pkg::*;
#(
  parameter int unsigned IMG_W   = DefImgW,
  parameter int unsigned IMG_H   = DefImgH,
  parameter int unsigned WIN_LAG = DefWinLag
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic sof_i,
  output logic qual_o,
  output logic frame_done_o
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [ColW-1:0] col_q, col_d, pix_col;
  logic [RowW-1:0] row_q, row_d, pix_row;
  logic            col_last, row_last;
  logic            frame_done_q, frame_done_d;

  // Position of the pixel being loaded (sof overrides the counters) and next counter state.
  always_comb begin
    pix_col      = sof_i ? '0 : col_q;
    pix_row      = sof_i ? '0 : row_q;
    col_last     = (pix_col == ColW'(IMG_W - 1));
    row_last     = (pix_row == RowW'(IMG_H - 1));
    col_d        = col_q;
    row_d        = row_q;
    qual_o       = 1'b0;
    frame_done_d = 1'b0;
    if (load_i) begin
      qual_o       = (32'(pix_col) >= WIN_LAG) && (32'(pix_row) >= 32'd2);
      // A last pixel that coincides with sof belongs to a new frame, not the old one.
      frame_done_d = col_last && row_last && !sof_i;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : pix_row + 1'b1;
      end else begin
        col_d = pix_col + 1'b1;
        row_d = pix_row;
      end
    end
  end

  // Counter and frame_done registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/sobel_edge3x3.sv
// Three-stage 3x3 Sobel gradient, L1 magnitude and threshold with border suppression.
module sobel_edge3x3
  import sobel_edge3x3_pkg::*;
#(
  parameter int unsigned IMG_W   = DefImgW,
  parameter int unsigned IMG_H   = DefImgH,
  parameter int unsigned WIN_LAG = DefWinLag,
  parameter int unsigned THRESH  = DefThresh
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             sof_i,
  input  logic [PIX_W-1:0] t1_i,
  input  logic [PIX_W-1:0] t2_i,
  input  logic [PIX_W-1:0] t3_i,
  input  logic [PIX_W-1:0] m1_i,
  input  logic [PIX_W-1:0] m2_i,
  input  logic [PIX_W-1:0] m3_i,
  input  logic [PIX_W-1:0] b1_i,
  input  logic [PIX_W-1:0] b2_i,
  input  logic [PIX_W-1:0] b3_i,
  output logic             out_valid_o,
  output logic [MAG_W-1:0] mag_o,
  output logic             edge_o,
  output logic             frame_done_o
);

  logic qual;

  win_pos_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .WIN_LAG(WIN_LAG)
  ) u_pos (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load_i),
    .sof_i       (sof_i),
    .qual_o      (qual),
    .frame_done_o(frame_done_o)
  );

  // The centre tap has zero weight in both kernels.
  logic unused_m2;
  assign unused_m2 = ^m2_i;

  sum_t sum_l_d, sum_r_d, sum_t_d, sum_b_d;
  sum_t sum_l_q, sum_r_q, sum_t_q, sum_b_q;
  sum_t abs_gx_d, abs_gy_d, abs_gx_q, abs_gy_q;
  mag_t mag_d, mag_q;
  logic edge_d, edge_q;
  logic vld1_q, vld2_q, vld3_q;

  // Next-state of each stage: weighted sums, absolute gradients, magnitude and threshold.
  always_comb begin
    sum_l_d  = wsum(t1_i, m1_i, b1_i);
    sum_r_d  = wsum(t3_i, m3_i, b3_i);
    sum_t_d  = wsum(t1_i, t2_i, t3_i);
    sum_b_d  = wsum(b1_i, b2_i, b3_i);
    abs_gx_d = abs_grad(sum_r_q, sum_l_q);
    abs_gy_d = abs_grad(sum_b_q, sum_t_q);
    mag_d    = mag_t'(abs_gx_q) + mag_t'(abs_gy_q);
    edge_d   = (mag_d >= mag_t'(THRESH));
  end

  // Free-running pipeline; only the token marks which beats carry a qualified window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      sum_t_q  <= '0;
      sum_b_q  <= '0;
      abs_gx_q <= '0;
      abs_gy_q <= '0;
      mag_q    <= '0;
      edge_q   <= 1'b0;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      vld3_q   <= 1'b0;
    end else begin
      sum_l_q  <= sum_l_d;
      sum_r_q  <= sum_r_d;
      sum_t_q  <= sum_t_d;
      sum_b_q  <= sum_b_d;
      abs_gx_q <= abs_gx_d;
      abs_gy_q <= abs_gy_d;
      mag_q    <= mag_d;
      edge_q   <= edge_d;
      vld1_q   <= qual;
      vld2_q   <= vld1_q;
      vld3_q   <= vld2_q;
    end
  end

  assign out_valid_o = vld3_q;
  assign mag_o       = mag_q;
  assign edge_o      = edge_q;

endmodule

// File: tb/tb_sobel_edge3x3.sv
// Directed bench with a scoreboard of expected outputs keyed by arrival cycle.
module tb_sobel_edge3x3;

  localparam int unsigned W   = 8;
  localparam int unsigned H   = 4;
  localparam int unsigned LAG = 5;
  localparam int unsigned TH  = 100;

  typedef logic [8:0][7:0] win_t;  // [0]=t1 [1]=t2 [2]=t3 [3]=m1 .. [8]=b3
  typedef struct {
    int          due;
    logic [10:0] mag;
    logic        edg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        load_i, sof_i;
  logic [7:0]  t1_i, t2_i, t3_i, m1_i, m2_i, m3_i, b1_i, b2_i, b3_i;
  logic        out_valid_o, edge_o, frame_done_o;
  logic [10:0] mag_o;

  exp_t sb_q[$];
  int   fd_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_vld = 0;
  int   n_fd = 0;
  int   bcol = 0;
  int   brow = 0;
  win_t slots[6];

  sobel_edge3x3 #(
    .IMG_W  (W),
    .IMG_H  (H),
    .WIN_LAG(LAG),
    .THRESH (TH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .load_i      (load_i),
    .sof_i       (sof_i),
    .t1_i        (t1_i),
    .t2_i        (t2_i),
    .t3_i        (t3_i),
    .m1_i        (m1_i),
    .m2_i        (m2_i),
    .m3_i        (m3_i),
    .b1_i        (b1_i),
    .b2_i        (b2_i),
    .b3_i        (b3_i),
    .out_valid_o (out_valid_o),
    .mag_o       (mag_o),
    .edge_o      (edge_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic win_t win(input int t1, input int t2, input int t3, input int m1,
                               input int m2, input int m3, input int b1, input int b2,
                               input int b3);
    return {8'(b3), 8'(b2), 8'(b1), 8'(m3), 8'(m2), 8'(m1), 8'(t3), 8'(t2), 8'(t1)};
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // Reference Sobel L1 magnitude from the kernel definitions.
  function automatic int exp_mag(input win_t w);
    int gx, gy;
    gx = (int'(w[2]) + 2 * int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2 * int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[1]) + int'(w[2]));
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  // Drive one cycle of stimulus and predict what it should produce.
  task automatic step(input logic ld, input logic sf, input win_t w);
    int m;
    @(negedge clk);
    load_i = ld;
    sof_i  = sf;
    {b3_i, b2_i, b1_i, m3_i, m2_i, m1_i, t3_i, t2_i, t1_i} = w;
    if (ld) begin
      if (sf) begin
        bcol = 0;
        brow = 0;
      end
      if (bcol >= int'(LAG) && brow >= 2) begin
        m = exp_mag(w);
        sb_q.push_back('{due: cyc + 3, mag: 11'(m), edg: (m >= int'(TH))});
      end
      if (!sf && bcol == int'(W) - 1 && brow == int'(H) - 1) fd_q.push_back(cyc + 1);
      bcol++;
      if (bcol == int'(W)) begin
        bcol = 0;
        brow++;
        if (brow == int'(H)) brow = 0;
      end
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      check("out_valid", 32'(out_valid_o), 32'd1);
      check("mag", 32'(mag_o), 32'(mon_e.mag));
      check("edge", 32'(edge_o), 32'(mon_e.edg));
    end else begin
      check("out_valid_idle", 32'(out_valid_o), 32'd0);
    end
    if (fd_q.size() > 0 && fd_q[0] == cyc) begin
      void'(fd_q.pop_front());
      check("frame_done", 32'(frame_done_o), 32'd1);
    end else begin
      check("frame_done_idle", 32'(frame_done_o), 32'd0);
    end
    if (out_valid_o === 1'b1) n_vld++;
    if (frame_done_o === 1'b1) n_fd++;
  end

  initial begin
    int base_v, base_f;
    win_t w;
    slots[0] = win(50, 50, 50, 50, 50, 50, 50, 50, 50);     // flat -> 0
    slots[1] = win(0, 0, 255, 0, 0, 255, 0, 0, 255);        // vertical step -> 1020
    slots[2] = win(0, 0, 255, 0, 0, 255, 255, 255, 255);    // combined edge
    slots[3] = win(0, 0, 25, 0, 0, 25, 0, 0, 25);           // mag == THRESH
    slots[4] = win(0, 0, 0, 0, 0, 49, 0, 0, 0);             // mag 98: L1 mag is always even
    slots[5] = rand_win();

    rst_ni = 1'b0;
    load_i = 1'b0;
    sof_i  = 1'b0;
    {b3_i, b2_i, b1_i, m3_i, m2_i, m1_i, t3_i, t2_i, t1_i} = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_mag", 32'(mag_o), 32'd0);
    check("rst_edge", 32'(edge_o), 32'd0);
    check("rst_frame_done", 32'(frame_done_o), 32'd0);
    rst_ni = 1'b1;

    // One full frame of back-to-back loads; qualified slots carry the directed windows.
    base_v = n_vld;
    base_f = n_fd;
    for (int i = 0; i < int'(W * H); i++) begin
      int c, r;
      c = i % int'(W);
      r = i / int'(W);
      if (c >= int'(LAG) && r >= 2) w = slots[(r - 2) * 3 + (c - int'(LAG))];
      else w = rand_win();
      step(1'b1, (i == 0), w);
    end
    repeat (6) step(1'b0, 1'b0, '0);
    check("frame_out_valid_count", 32'(n_vld - base_v), 32'd6);
    check("frame_done_count", 32'(n_fd - base_f), 32'd1);

    // Two qualified loads (col 5 and 6 of row 2), then a one-cycle reset.
    for (int i = 0; i < 23; i++) step(1'b1, (i == 0), rand_win());
    @(negedge clk);
    rst_ni = 1'b0;
    load_i = 1'b0;
    sof_i  = 1'b0;
    sb_q.delete();
    fd_q.delete();
    bcol = 0;
    brow = 0;
    #1;
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (5) step(1'b0, 1'b0, '0);

    // Counters must restart from 0: without sof, only loads 21..23 qualify.
    base_v = n_vld;
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, rand_win());
    repeat (5) step(1'b0, 1'b0, '0);
    check("post_reset_out_valid_count", 32'(n_vld - base_v), 32'd3);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
